// File: rtl/alu_pkg.sv
// Shared constants for the signed ALU and its issue controller: widths, opcodes, FSM states.
// TAG_W is only present when TAG_EN is defined.
package alu_pkg;

   localparam int IN_W  = 32;
   localparam int OUT_W = 64;
   localparam int OP_W  = 3;
`ifdef TAG_EN
   localparam int TAG_W = 4;
`endif

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_MUL = 3'b001;
   localparam logic [OP_W-1:0] OP_MAD = 3'b010;

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      MAD2,
      RESP
   } state_t;

   function automatic logic isValidOp(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_MUL) || (op == OP_MAD);
   endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational signed ALU: one command in flight, MAD done as MUL then a local add.
// Optional macro TAG_EN adds cmd_tag/res_tag and a tag register echoed with the result.
module alu_issue_ctrl
   import alu_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [OP_W-1:0]  cmd_op,
   input  logic [IN_W-1:0]  cmd_a,
   input  logic [IN_W-1:0]  cmd_b,
   input  logic [IN_W-1:0]  cmd_c,
`ifdef TAG_EN
   input  logic [TAG_W-1:0] cmd_tag,
   output logic [TAG_W-1:0] res_tag,
`endif
   output logic [OP_W-1:0]  alu_op_code,
   output logic [IN_W-1:0]  alu_in1,
   output logic [IN_W-1:0]  alu_in2,
   input  logic [OUT_W-1:0] alu_out,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [OUT_W-1:0] res_data,
   output logic             res_err
);

   state_t            r_state;
   logic [OP_W-1:0]   r_op;
   logic [OP_W-1:0]   r_aluOp;
   logic [IN_W-1:0]   r_aluIn1;
   logic [IN_W-1:0]   r_aluIn2;
   logic [IN_W-1:0]   r_c;
   logic [OUT_W-1:0]  r_prod;
   logic [OUT_W-1:0]  r_resData;
   logic              r_resValid;
   logic              r_resErr;
`ifdef TAG_EN
   logic [TAG_W-1:0]  r_tag;
`endif

   logic              w_accept;
   logic [OUT_W-1:0]  w_madSum;

   assign cmd_ready = rst_n && (r_state == IDLE);
   assign w_accept  = cmd_valid && cmd_ready;
   assign w_madSum  = r_prod + {{(OUT_W-IN_W){r_c[IN_W-1]}}, r_c};

   assign alu_op_code = r_aluOp;
   assign alu_in1     = r_aluIn1;
   assign alu_in2     = r_aluIn2;
   assign res_valid   = r_resValid;
   assign res_data    = r_resData;
   assign res_err     = r_resErr;
`ifdef TAG_EN
   assign res_tag     = r_tag;
`endif

   // ALU drive registers load only on acceptance, so the ALU inputs hold between commands.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_op       <= '0;
         r_aluOp    <= '0;
         r_aluIn1   <= '0;
         r_aluIn2   <= '0;
         r_c        <= '0;
         r_prod     <= '0;
         r_resData  <= '0;
         r_resValid <= 1'b0;
         r_resErr   <= 1'b0;
`ifdef TAG_EN
         r_tag      <= '0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_op     <= cmd_op;
                  r_aluOp  <= (cmd_op == OP_MAD) ? OP_MUL : cmd_op;
                  r_aluIn1 <= cmd_a;
                  r_aluIn2 <= cmd_b;
                  r_c      <= cmd_c;
`ifdef TAG_EN
                  r_tag    <= cmd_tag;
`endif
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               if (r_op == OP_MAD) begin
                  r_prod  <= alu_out;
                  r_state <= MAD2;
               end else begin
                  r_resData  <= alu_out;
                  r_resErr   <= !isValidOp(r_op);
                  r_resValid <= 1'b1;
                  r_state    <= RESP;
               end
            end
            MAD2: begin
               r_resData  <= w_madSum;
               r_resErr   <= 1'b0;
               r_resValid <= 1'b1;
               r_state    <= RESP;
            end
            RESP: begin
               if (res_ready) begin
                  r_resValid <= 1'b0;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
